// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA exponentiation control path:
//   - default exponent / bit-counter widths
//   - multiplier command encodings (op_sel)
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package rsa_pkg;

   localparam int EXP_W_DEFAULT = 32;
   localparam int CNT_W_DEFAULT = 6;

   // op_sel encodings presented to the modular-multiplier datapath
   localparam logic OP_SQUARE = 1'b0;  // R * R
   localparam logic OP_MULT   = 1'b1;  // R * M

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_SQ_ISSUE  = 3'd2,
      ST_SQ_WAIT   = 3'd3,
      ST_MUL_ISSUE = 3'd4,
      ST_MUL_WAIT  = 3'd5,
      ST_NEXT      = 3'd6,
      ST_FINISH    = 3'd7
   } state_e;

endpackage

// File: rtl/rsa_bit_cnt.sv
// -----------------------------------------------------------------------------
// rsa_bit_cnt
// Loadable down-counter tracking how many exponent bits remain.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (count clears to 0)
//   load        load load_val this cycle (has priority over dec)
//   load_val    value to load
//   dec         decrement by one
//   cnt         current count
//   last        high when cnt == 1 (the bit being processed is the final one)
// -----------------------------------------------------------------------------
module rsa_bit_cnt
   import rsa_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: assign the default first so every path writes cnt_d; otherwise a latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rsa_exp_sequencer.sv
// -----------------------------------------------------------------------------
// rsa_exp_sequencer
// Square-and-multiply control sequencer. Walks the captured exponent MSB-first
// over exp_len bits, issuing one square per bit and one multiply per set bit
// to the modular multiplier over a valid/ready command interface.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       begin exponentiation (sampled only in IDLE)
//   exp         exponent, captured on accepted start
//   exp_len     number of significant exponent bits (valid 1..EXP_W)
//   op_valid    command valid to the multiplier
//   op_sel      OP_SQUARE / OP_MULT, stable while op_valid is waiting
//   op_ready    multiplier accepts the command this cycle
//   res_valid   one-cycle completion strobe for the issued command
//   busy        high from LOAD through FINISH
//   done        one-cycle completion pulse
//   err         last start had an invalid exp_len; held until next start
// Configuration macro: RSA_SKIP_UNIT_SQ_EN -- when defined, squares are
//   suppressed until the first multiply has completed (accumulator is still 1).
// -----------------------------------------------------------------------------
module rsa_exp_sequencer
   import rsa_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [EXP_W-1:0] exp,
   input  logic [CNT_W-1:0] exp_len,
   output logic             op_valid,
   output logic             op_sel,
   input  logic             op_ready,
   input  logic             res_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state_q, state_d;
   logic [EXP_W-1:0] exp_reg_q, exp_reg_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             start_acc;
   logic             len_bad;
   logic [CNT_W-1:0] bit_idx;
   logic             cur_bit;
   logic             sq_en;

   assign start_acc = (state_q == ST_IDLE) && start;
   assign len_bad   = (cnt == '0) || (cnt > CNT_W'(EXP_W));
   assign bit_idx   = cnt - CNT_W'(1);
   // Mask-and-reduce selects exp_reg[cnt-1] without an over-wide index.
   assign cur_bit   = |(exp_reg_q & (EXP_W'(1) << bit_idx));

`ifdef RSA_SKIP_UNIT_SQ_EN
   logic mul_seen_q, mul_seen_d;

   always_comb begin
      mul_seen_d = mul_seen_q;
      if (start_acc) begin
         mul_seen_d = 1'b0;
      end else if ((state_q == ST_MUL_WAIT) && res_valid) begin
         mul_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mul_seen_q <= 1'b0;
      end else begin
         mul_seen_q <= mul_seen_d;
      end
   end

   // Squaring 1 is pointless, so squares wait until a multiply has landed.
   assign sq_en = mul_seen_q;
`else
   assign sq_en = 1'b1;
`endif

   rsa_bit_cnt #(
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_acc),
      .load_val (exp_len),
      .dec      ((state_q == ST_NEXT) && !cnt_last),
      .cnt      (cnt),
      .last     (cnt_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (start) state_d = ST_LOAD;
         ST_LOAD:      state_d = len_bad ? ST_FINISH : ST_SQ_ISSUE;
         ST_SQ_ISSUE: begin
            if (!sq_en) begin
               state_d = cur_bit ? ST_MUL_ISSUE : ST_NEXT;
            end else if (op_ready) begin
               state_d = ST_SQ_WAIT;
            end
         end
         ST_SQ_WAIT:   if (res_valid) state_d = cur_bit ? ST_MUL_ISSUE : ST_NEXT;
         ST_MUL_ISSUE: if (op_ready) state_d = ST_MUL_WAIT;
         ST_MUL_WAIT:  if (res_valid) state_d = ST_NEXT;
         ST_NEXT:      state_d = cnt_last ? ST_FINISH : ST_SQ_ISSUE;
         ST_FINISH:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Exponent and error registers
   always_comb begin
      exp_reg_d = exp_reg_q;
      err_d     = err_q;
      if (start_acc) begin
         exp_reg_d = exp;
         err_d     = 1'b0;
      end else if ((state_q == ST_LOAD) && len_bad) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   // NOTE: exp_reg is pure data, always reloaded before use, so it carries no reset.
   always_ff @(posedge clk) begin
      exp_reg_q <= exp_reg_d;
   end

   // Outputs: decodes of registered state only, so op_valid never depends on op_ready.
   always_comb begin
      op_valid = 1'b0;
      op_sel   = OP_SQUARE;
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_FINISH);
      err      = err_q;
      unique case (state_q)
         ST_SQ_ISSUE:  op_valid = sq_en;
         ST_MUL_ISSUE: begin
            op_valid = 1'b1;
            op_sel   = OP_MULT;
         end
         default: ;
      endcase
   end

endmodule
